// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM states, AXI constants and address-split widths for icache_sa.
package cache_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, REQ, TRANS, RESP} state_e;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  function automatic int off_bits(input int block_size);
    return $clog2(block_size);
  endfunction
  function automatic int idx_bits(input int set_num);
    return $clog2(set_num);
  endfunction
  function automatic int tag_bits(input int block_size, input int set_num);
    return 32 - $clog2(block_size) - $clog2(set_num);
  endfunction
endpackage

// File: rtl/cache_victim_sel.sv
// cache_victim_sel: picks the install way (lowest invalid, else per-set round-robin pointer).
module cache_victim_sel #(
  parameter int SET_NUM = 8,
  parameter int WAYS = 2,
  parameter int IW = 3,
  parameter int WW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_clr,
  input  logic            advance,
  input  logic [IW-1:0]   set_idx,
  input  logic [WAYS-1:0] valid_row,
  output logic [WW-1:0]   victim
);
  logic [WW-1:0] ptr_q [SET_NUM];
  logic [WW-1:0] ptr_d [SET_NUM];
  logic [WW-1:0] free_way;
  logic all_valid;
  always_comb begin
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) free_way = !valid_row[w] ? WW'(w) : free_way;
    all_valid = &valid_row;
    victim = all_valid ? ptr_q[set_idx] : free_way;
  end
  always_comb begin
    ptr_d = ptr_q;
    if (flush_clr) ptr_d = '{default: '0};
    else if (advance && &valid_row)
      ptr_d[set_idx] = ptr_q[set_idx] == WW'(WAYS - 1) ? '0 : ptr_q[set_idx] + WW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '{default: '0};
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/icache_sa.sv
// icache_sa: N-way set-associative read-only cache with INCR burst block refill and flush.
module icache_sa
  import cache_pkg::*;
#(
  parameter int BLOCK_SIZE = 16,
  parameter int SET_NUM = 8,
  parameter int WAYS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_arvalid,
  output logic        in_arready,
  input  logic [31:0] in_araddr,
  input  logic [3:0]  in_arid,
  input  logic [7:0]  in_arlen,
  input  logic [2:0]  in_arsize,
  input  logic [1:0]  in_arburst,
  output logic        in_rvalid,
  input  logic        in_rready,
  output logic [31:0] in_rdata,
  output logic [1:0]  in_rresp,
  output logic        in_rlast,
  output logic [3:0]  in_rid,
  output logic        out_arvalid,
  input  logic        out_arready,
  output logic [31:0] out_araddr,
  output logic [3:0]  out_arid,
  output logic [7:0]  out_arlen,
  output logic [2:0]  out_arsize,
  output logic [1:0]  out_arburst,
  input  logic        out_rvalid,
  output logic        out_rready,
  input  logic [31:0] out_rdata,
  input  logic [1:0]  out_rresp,
  input  logic        out_rlast,
  input  logic [3:0]  out_rid
);
  localparam int BEATS = BLOCK_SIZE / 4;
  localparam int OFF = off_bits(BLOCK_SIZE);
  localparam int IW = idx_bits(SET_NUM);
  localparam int TW = tag_bits(BLOCK_SIZE, SET_NUM);
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int CW = $clog2(BEATS) + 1;
  localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1;
  state_e state_q, state_d;
  logic [31:0] addr_q, addr_d, rdata_q, rdata_d;
  logic [3:0] id_q, id_d;
  logic [1:0] rresp_q, rresp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, flush_pend_q, flush_pend_d;
  logic [31:0] lbuf_q [BEATS], lbuf_d [BEATS], line_w [BEATS];
  logic [WAYS-1:0] valid_q [SET_NUM], valid_d [SET_NUM];
  logic [TW-1:0] tag_q [SET_NUM][WAYS], tag_d [SET_NUM][WAYS];
  logic [31:0] data_q [SET_NUM][WAYS][BEATS], data_d [SET_NUM][WAYS][BEATS];
  logic [IW-1:0] set_idx;
  logic [TW-1:0] tag;
  logic [BW-1:0] word;
  logic [WAYS-1:0] hit_vec;
  logic [31:0] hit_word;
  logic [WW-1:0] victim;
  logic take, install, flush_clr, unused_ok;
  assign set_idx = addr_q[OFF +: IW];
  assign tag = addr_q[31 -: TW];
  assign word = BW'(addr_q[31:2] & 30'(BEATS - 1));
  assign take = state_q == TRANS && out_rvalid && cnt_q < CW'(BEATS);
  // Install only when rlast lands exactly on the last beat of a clean burst.
  assign install = state_q == TRANS && out_rvalid && out_rlast && cnt_q == CW'(BEATS - 1)
                   && !err_q && out_rresp == RESP_OKAY;
  assign flush_clr = state_q == IDLE && flush_pend_q;
  assign unused_ok = ^{in_arlen, in_arsize, in_arburst, out_rid, addr_q[1:0]};
  cache_victim_sel #(.SET_NUM(SET_NUM), .WAYS(WAYS), .IW(IW), .WW(WW)) u_victim (
    .clk(clk), .rst(rst), .flush_clr(flush_clr), .advance(install),
    .set_idx(set_idx), .valid_row(valid_q[set_idx]), .victim(victim)
  );
  always_comb begin
    hit_vec = '0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[set_idx][w] && tag_q[set_idx][w] == tag;
      hit_word = hit_word | (hit_vec[w] ? data_q[set_idx][w][word] : 32'h0);
    end
    for (int b = 0; b < BEATS; b++) line_w[b] = take && cnt_q == CW'(b) ? out_rdata : lbuf_q[b];
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    id_d = id_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    cnt_d = cnt_q;
    err_d = err_q;
    lbuf_d = lbuf_q;
    valid_d = valid_q;
    tag_d = tag_q;
    data_d = data_q;
    flush_pend_d = flush_pend_q || flush;
    case (state_q)
      IDLE:
        if (flush_pend_q) begin
          valid_d = '{default: '0};
          flush_pend_d = flush;
        end else if (in_arvalid && in_arready) begin
          addr_d = in_araddr;
          id_d = in_arid;
          state_d = CHECK;
        end
      CHECK: begin
        state_d = |hit_vec ? RESP : REQ;
        rdata_d = |hit_vec ? hit_word : rdata_q;
        rresp_d = |hit_vec ? RESP_OKAY : rresp_q;
        cnt_d = '0;
        err_d = 1'b0;
      end
      REQ: state_d = out_arready ? TRANS : REQ;
      TRANS:
        if (out_rvalid) begin
          lbuf_d = line_w;
          cnt_d = cnt_q == CW'(BEATS) ? cnt_q : cnt_q + CW'(1);
          err_d = err_q || out_rresp != RESP_OKAY;
          if (out_rlast) begin
            state_d = RESP;
            rdata_d = install ? line_w[word] : '0;
            rresp_d = install ? RESP_OKAY : RESP_SLVERR;
          end
          if (install) begin
            valid_d[set_idx][victim] = 1'b1;
            tag_d[set_idx][victim] = tag;
            data_d[set_idx][victim] = line_w;
          end
        end
      RESP: state_d = in_rready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      id_q <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      cnt_q <= '0;
      err_q <= 1'b0;
      flush_pend_q <= 1'b0;
      valid_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      id_q <= id_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      flush_pend_q <= flush_pend_d;
      valid_q <= valid_d;
    end
    lbuf_q <= lbuf_d;
    tag_q <= tag_d;
    data_q <= data_d;
  end
  assign in_arready = state_q == IDLE && !flush_pend_q && !flush;
  assign in_rvalid = state_q == RESP;
  assign in_rlast = in_rvalid;
  assign in_rdata = rdata_q;
  assign in_rresp = rresp_q;
  assign in_rid = id_q;
  assign out_arvalid = state_q == REQ;
  assign out_araddr = {addr_q[31:OFF], {OFF{1'b0}}};
  assign out_arid = id_q;
  assign out_arlen = 8'(BEATS - 1);
  assign out_arsize = AXI_SIZE_4B;
  assign out_arburst = AXI_BURST_INCR;
  assign out_rready = state_q == TRANS;
endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: randomized bench checking icache_sa against a line-level cache model.
module tb_icache_sa;
  import cache_pkg::*;
  localparam int BS = 16, SN = 8, WY = 2, BEATS = BS / 4;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic in_arvalid = 1'b0, in_arready;
  logic [31:0] in_araddr = '0;
  logic [3:0] in_arid = '0;
  logic [7:0] in_arlen = '0;
  logic [2:0] in_arsize = AXI_SIZE_4B;
  logic [1:0] in_arburst = AXI_BURST_INCR;
  logic in_rvalid, in_rready = 1'b0, in_rlast;
  logic [31:0] in_rdata;
  logic [1:0] in_rresp;
  logic [3:0] in_rid;
  logic out_arvalid, out_arready = 1'b0;
  logic [31:0] out_araddr;
  logic [3:0] out_arid;
  logic [7:0] out_arlen;
  logic [2:0] out_arsize;
  logic [1:0] out_arburst;
  logic out_rvalid = 1'b0, out_rready, out_rlast = 1'b0;
  logic [31:0] out_rdata = '0;
  logic [1:0] out_rresp = '0;
  logic [3:0] out_rid = '0;
  int vecs = 0, errs = 0;
  logic [31:0] exp_data, exp_araddr, last_rdata, seen_araddr;
  logic [1:0] exp_resp, last_rresp;
  logic [3:0] exp_id;
  bit last_hit, mpend;
  bit mv [SN][WY];
  logic [31:0] mt [SN][WY];
  int mp [SN];
  always #5 clk = ~clk;
  icache_sa #(.BLOCK_SIZE(BS), .SET_NUM(SN), .WAYS(WY)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_arvalid(in_arvalid), .in_arready(in_arready), .in_araddr(in_araddr), .in_arid(in_arid),
    .in_arlen(in_arlen), .in_arsize(in_arsize), .in_arburst(in_arburst),
    .in_rvalid(in_rvalid), .in_rready(in_rready), .in_rdata(in_rdata), .in_rresp(in_rresp),
    .in_rlast(in_rlast), .in_rid(in_rid),
    .out_arvalid(out_arvalid), .out_arready(out_arready), .out_araddr(out_araddr), .out_arid(out_arid),
    .out_arlen(out_arlen), .out_arsize(out_arsize), .out_arburst(out_arburst),
    .out_rvalid(out_rvalid), .out_rready(out_rready), .out_rdata(out_rdata), .out_rresp(out_rresp),
    .out_rlast(out_rlast), .out_rid(out_rid)
  );
  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a & 32'hFFFF_FFFC) ^ 32'h5A5A_0000;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic mclear();
    for (int s = 0; s < SN; s++) begin
      mp[s] = 0;
      for (int w = 0; w < WY; w++) mv[s][w] = 1'b0;
    end
  endtask
  task automatic minstall(input logic [31:0] a);
    int s, v;
    s = int'((a / BS) % SN);
    v = -1;
    for (int w = WY - 1; w >= 0; w--) if (!mv[s][w]) v = w;
    if (v < 0) begin
      v = mp[s];
      mp[s] = (mp[s] + 1) % WY;
    end
    mv[s][v] = 1'b1;
    mt[s][v] = a / (BS * SN);
  endtask
  task automatic rst_chk(input string tag);
    chk({tag, "_rvalid"}, in_rvalid, 0);
    chk({tag, "_arvalid"}, out_arvalid, 0);
    chk({tag, "_rdata"}, in_rdata, 0);
    chk({tag, "_rresp"}, in_rresp, 0);
    chk({tag, "_rid"}, in_rid, 0);
    chk({tag, "_arready"}, in_arready, 1);
    chk({tag, "_rready"}, out_rready, 0);
  endtask
  always @(negedge clk) if (!rst) begin
    if (in_rvalid) begin
      chk("rdata", in_rdata, exp_data);
      chk("rresp", in_rresp, exp_resp);
      chk("rid", in_rid, exp_id);
      chk("rlast", in_rlast, 1);
      chk("arready_busy", in_arready, 0);
    end
    if (out_arvalid) begin
      chk("araddr", out_araddr, exp_araddr);
      chk("arid", out_arid, exp_id);
      chk("arlen", out_arlen, BEATS - 1);
      chk("arsize", out_arsize, 3'b010);
      chk("arburst", out_arburst, 2'b01);
      chk("arready_req", in_arready, 0);
    end
  end
  task automatic rd(input logic [31:0] a, input int eb, input int nb, input int hold, input bit fl, input int rst_at);
    int s, n;
    bit mh, good, missed;
    s = int'((a / BS) % SN);
    mh = 1'b0;
    for (int w = 0; w < WY; w++) if (mv[s][w] && mt[s][w] == a / (BS * SN)) mh = 1'b1;
    good = !(eb >= 0 && eb < nb) && nb == BEATS;
    exp_id = 4'($urandom);
    exp_araddr = a - a % BS;
    exp_data = (mh || good) ? memw(a) : 32'h0;
    exp_resp = (mh || good) ? 2'b00 : 2'b10;
    chk("arready_idle", in_arready, 1);
    in_arvalid = 1'b1;
    in_araddr = a;
    in_arid = exp_id;
    @(negedge clk);
    in_arvalid = 1'b0;
    in_araddr = $urandom;
    in_arid = 4'($urandom);
    chk("check_rvalid", in_rvalid, 0);
    chk("check_arvalid", out_arvalid, 0);
    @(negedge clk);
    last_hit = in_rvalid;
    missed = out_arvalid;
    chk("hit_rvalid", in_rvalid, mh);
    chk("miss_arvalid", out_arvalid, !mh);
    if (missed) begin
      seen_araddr = out_araddr;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      out_arready = 1'b1;
      @(negedge clk);
      out_arready = 1'b0;
      for (int i = 0; i < nb; i++) begin
        repeat ($urandom_range(0, 1)) begin
          out_rvalid = 1'b0;
          @(negedge clk);
        end
        if (i == rst_at) begin
          out_rvalid = 1'b0;
          rst = 1'b1;
          @(negedge clk);
          rst_chk("midrst");
          rst = 1'b0;
          mclear();
          mpend = 1'b0;
          return;
        end
        out_rvalid = 1'b1;
        out_rdata = memw(exp_araddr + 32'(4 * i));
        out_rresp = i == eb ? 2'b10 : 2'b00;
        out_rlast = i == nb - 1;
        out_rid = exp_id;
        flush = fl && i == 1;
        if (flush) mpend = 1'b1;
        chk("out_rready", out_rready, 1);
        @(negedge clk);
        flush = 1'b0;
      end
      out_rvalid = 1'b0;
      out_rlast = 1'b0;
      chk("miss_latency", in_rvalid, 1);
    end
    n = 0;
    while (!in_rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_rvalid) begin
      chk("resp_timeout", in_rvalid, 1);
      return;
    end
    repeat (hold) @(negedge clk);
    last_rdata = in_rdata;
    last_rresp = in_rresp;
    in_rready = 1'b1;
    @(negedge clk);
    in_rready = 1'b0;
    chk("resp_done", in_rvalid, 0);
    if (!mh && good) minstall(a);
    if (mpend) begin
      chk("flush_idle_ar", in_arready, 0);
      @(negedge clk);
      mclear();
      mpend = 1'b0;
    end
  endtask
  task automatic do_flush();
    flush = 1'b1;
    #1 chk("flush_ar_now", in_arready, 0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ar_pend", in_arready, 0);
    @(negedge clk);
    mclear();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: no finish after 1ms");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] a;
    int eb, nb, ra;
    mclear();
    mpend = 1'b0;
    repeat (3) @(negedge clk);
    rst_chk("por");
    rst = 1'b0;
    rd(32'h8000_0014, -1, BEATS, 0, 1'b0, -1);
    chk("pin_araddr", seen_araddr, 32'h8000_0010);
    chk("pin_A1", last_rdata, 32'hDA5A_0014);
    rd(32'h8000_0018, -1, BEATS, 0, 1'b0, -1);
    chk("pin_hit_A2", last_hit, 1);
    chk("pin_A2", last_rdata, 32'hDA5A_0018);
    do_flush();
    rd(32'h0000_0000, -1, BEATS, 0, 1'b0, -1);
    rd(32'h0000_0080, -1, BEATS, 0, 1'b0, -1);
    rd(32'h0000_0100, -1, BEATS, 0, 1'b0, -1);
    rd(32'h0000_0080, -1, BEATS, 0, 1'b0, -1);
    chk("pin_evict_keep", last_hit, 1);
    rd(32'h0000_0000, -1, BEATS, 0, 1'b0, -1);
    chk("pin_evict_gone", last_hit, 0);
    rd(32'h2000_0044, 2, BEATS, 0, 1'b0, -1);
    chk("pin_err_resp", last_rresp, 2'b10);
    chk("pin_err_data", last_rdata, 0);
    rd(32'h2000_0044, -1, BEATS, 0, 1'b0, -1);
    chk("pin_err_refetch", last_hit, 0);
    rd(32'h2000_0048, -1, BEATS, 5, 1'b0, -1);
    chk("pin_hold_hit", last_hit, 1);
    rd(32'h3000_0050, -1, BEATS, 0, 1'b1, -1);
    rd(32'h3000_0050, -1, BEATS, 0, 1'b0, -1);
    chk("pin_flush_miss", last_hit, 0);
    rd(32'h4000_0060, -1, BEATS + 2, 0, 1'b0, -1);
    chk("pin_long_resp", last_rresp, 2'b10);
    rd(32'h4000_0064, -1, BEATS - 2, 0, 1'b0, -1);
    chk("pin_short_resp", last_rresp, 2'b10);
    rd(32'h5000_0070, -1, BEATS, 0, 1'b0, 2);
    rd(32'h2000_0048, -1, BEATS, 0, 1'b0, -1);
    chk("pin_rst_miss", last_hit, 0);
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 19) == 0) do_flush();
      else begin
        a = (32'($urandom_range(0, 1)) << 31) | (32'($urandom_range(0, 3)) << 7)
          | (32'($urandom_range(0, 7)) << 4) | (32'($urandom_range(0, 3)) << 2);
        eb = $urandom_range(0, 7) == 0 ? int'($urandom_range(0, BEATS - 1)) : -1;
        nb = $urandom_range(0, 15) == 0 ? (($urandom_range(0, 1) != 0) ? BEATS + 1 : BEATS - 1) : BEATS;
        ra = $urandom_range(0, 49) == 0 ? int'($urandom_range(0, BEATS - 1)) : -1;
        rd(a, eb, nb, int'($urandom_range(0, 3)), $urandom_range(0, 19) == 0, ra);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised set-associative, read-only cache between the fetch unit's AXI4 read master and the memory-side AXI4 read port. It is the successor of the direct-mapped single-word cache and adds multi-word blocks with INCR burst refill, N-way associativity with round-robin replacement, a flush input for fence.i, refill error reporting, and an R-channel that holds until accepted. Upstream requests are single-beat 32-bit reads; downstream refills are bursts of one full block.

## Interface
- BLOCK_SIZE, 16: bytes per block, power of 2, ≥4; beats per refill BEATS = BLOCK_SIZE/4
- SET_NUM, 8: sets, power of 2, ≥2
- WAYS, 2: ways per set, power of 2, ≥1
- clk  in  1  clock; the block uses one clock
- rst  in  1  reset, synchronous and active-high
- flush  in  1  one-cycle pulse; invalidate every line
- in_arvalid / in_arready  in/out  1  upstream AR handshake
- in_araddr  in  32  byte address; bits [1:0] are ignored
- in_arid  in  4  transaction ID, echoed on in_rid
- in_arlen / in_arsize / in_arburst  in  8/3/2  accepted but unused; callers drive 0 / 3'b010 / INCR
- in_rvalid / in_rready  out/in  1  upstream R handshake
- in_rdata  out  32  requested word
- in_rresp  out  2  OKAY (2'b00) or SLVERR (2'b10)
- in_rlast  out  1  equals in_rvalid
- in_rid  out  4  captured in_arid
- out_arvalid / out_arready  out/in  1  refill AR handshake
- out_araddr  out  32  block-aligned refill address
- out_arid  out  4  captured in_arid
- out_arlen  out  8  constant BEATS-1
- out_arsize  out  3  constant 3'b010
- out_arburst  out  2  constant 2'b01 (INCR)
- out_rvalid / out_rready  in/out  1  refill R handshake; out_rready is 1 only in TRANS
- out_rdata / out_rresp / out_rlast / out_rid  in  32/2/1/4  refill beat

## Operation
- Address split: offset = [log2(BLOCK_SIZE)-1:0], index = next log2(SET_NUM) bits, tag = remaining bits. Word select = offset[OFF-1:2].
- States: IDLE, CHECK, REQ, TRANS, RESP.
- IDLE: in_arready = !flush_pending && !flush. On handshake, capture address and ID, then go to CHECK.
- CHECK: compare the tag across all ways of the set.
  - Hit: latch the word, rresp = OKAY, go to RESP.
  - Miss: go to REQ.
- REQ: out_arvalid = 1 with a stable address until out_arready is seen, then go to TRANS.
- TRANS: accept each beat into a BLOCK_SIZE line buffer at the beat counter. Set an error flag if any beat has rresp ≠ OKAY. On the rlast beat:
  - Counter == BEATS-1 and no error: write the tag, data, and valid bit into the victim way. The response word comes from the line buffer, with OKAY.
  - Otherwise: no install, respond SLVERR with rdata = 0.
  - Either way, go to RESP.
- Beats after the BEATS-th beat and before rlast are dropped, and the response is SLVERR.
- Victim: the lowest-index invalid way; if all ways are valid, the per-set round-robin pointer, which then increments modulo WAYS. Hits do not move the pointer.
- RESP: in_rvalid = 1 and data is held until in_rready, then go to IDLE.
- Flush: a pulse in any state sets flush_pending. In IDLE with flush_pending, clear all valid bits and pointers in one cycle and accept no request that cycle. An in-flight refill completes and installs, then is cleared by the pending flush.
- Reset:
  - state = IDLE; all valid bits, pointers, and flush_pending = 0.
  - in_rvalid, out_arvalid, in_rdata, in_rresp, in_rid = 0.
  - in_arready = 1 on the first cycle after reset.
  - Reset mid-burst abandons the refill; remaining downstream beats are not consumed.

## Timing
- Hit: AR handshake at edge T, CHECK during cycle T+1, in_rvalid high from T+2. Latency is 2 cycles.
- Miss: out_arvalid is high from T+2. Data arrives at (last-beat edge)+1 cycle.
- No request is accepted while any state other than IDLE is active; one transaction is outstanding.
- out_rready is combinationally 1 in TRANS, so no refill backpressure.

## Structure
- Shared package cache_pkg:
  - state enum
  - AXI_BURST_INCR, AXI_SIZE_4B, RESP_OKAY, RESP_SLVERR
  - address-split widths derived as functions of the parameters
- Sub-module cache_victim_sel: per-set round-robin pointers plus invalid-way priority, with flush clear.
- Tag/data/valid arrays stay as registers in the top.

## Test plan
- Cold miss at 0x8000_0014 with BLOCK_SIZE=16 → out_araddr 0x8000_0010, out_arlen 3. Beats A0..A3 → in_rdata = A1, OKAY. A repeat read of 0x8000_0018 hits and returns A2 two cycles after the handshake.
- WAYS=2, SET_NUM=8: reads of 0x0000_0000, 0x0000_0080, 0x0000_0100 (same set) → third access evicts way 0. Re-read 0x0000_0080 hits; 0x0000_0000 misses.
- Refill with beat 2 rresp=SLVERR → in_rresp=2'b10, rdata 0. The next read of the same address misses again.
- Hold in_rready=0 for 5 cycles in RESP → in_rvalid, in_rdata, in_rid stable; in_arready stays 0.
- Flush pulse during TRANS → refill completes, then in_arready=0 for one IDLE cycle. The following read of the refilled address misses.
- Assert rst during TRANS → next cycle: state IDLE, all outputs at reset values. Any address misses afterward.
